channel_dq_arbiter: RTL and testbench
=====================================

// Module: channel_dq_arbiter
// PURPOSE
//  Registered channel-level DQ/DQS data-path arbiter sitting between N rank models and the shared channel DQ bus.
//  Grants the bus to one rank per burst and steers read data onto DQ with generated DQS.
//  Routes controller write data to the owning rank only, enforces a rank/direction turnaround gap,
//  and flags bus contention and protocol errors.
// PARAMETERS
//  NUMRANK        4   ranks sharing the channel (>=1)
//  MEM_DATAWIDTH  64  DQ width in bits
//  BURST_LENGTH   8   beats per burst, one beat per clk (power of 2, >=2)
//  TURNAROUND     2   min idle cycles on rank or direction change (0 = none)
// PORTS
//  clk            in   1                     clock
//  rst_n          in   1                     reset
//  rank_rd_valid  in   NUMRANK               rank i drives a read beat
//  rank_rd_data   in   NUMRANK*MEM_DATAWIDTH rank i read beat, lane i = bits [i*W +: W]
//  rank_wr_valid  in   NUMRANK               rank i expects a write beat
//  dq_in          in   MEM_DATAWIDTH         controller write beat from DQ
//  dm_n_in        in   MEM_DATAWIDTH/8       write data mask, active-low
//  err_clear      in   1                     clears all sticky error flags
//  dq_out         out  MEM_DATAWIDTH         read beat to channel DQ
//  dq_oe          out  1                     DQ output enable
//  dqs_t/dqs_c    out  1 each                read strobe pair
//  dqs_oe         out  1                     DQS output enable
//  rank_wr_data   out  NUMRANK*MEM_DATAWIDTH write beat, owner lane only, others 0
//  rank_wr_strb   out  NUMRANK*MEM_DATAWIDTH/8  dm_n to owner lane, others all-1
//  rank_wr_en     out  NUMRANK               one-hot write-beat strobe
//  active_rank    out  $clog2(NUMRANK)>0?..:1  current/last owner index
//  bus_state      out  2                     0 IDLE, 1 RD, 2 WR, 3 GAP
//  err_collision  out  1                     sticky: >1 rank valid, or non-owner valid
//  err_short      out  1                     sticky: owner valid dropped mid-burst
//  err_turnaround out  1                     sticky: valid seen in GAP
//  Clocking: one clock, clk. Reset rst_n is synchronous and active-low.
// BEHAVIOUR
//  Reset: state IDLE; beat count 0; active_rank 0; all enables 0; dq_out/rank_wr_data 0; rank_wr_strb all-1;
//   dqs_t 0, dqs_c 1; errors 0.
//  Grant (IDLE): lowest-index rank with rd or wr valid wins; rd beats wr on the same index.
//   >1 distinct rank valid sets err_collision; the grant proceeds.
//  Data path: all outputs are registered, 1-cycle latency from input valid.
//   RD beat: dq_out = owner lane, dq_oe = dqs_oe = 1. WR beat: owner rank_wr_en = 1 with dq_in/dm_n_in.
//  Beat counter: increments per owner beat, wraps at BURST_LENGTH-1 -> 0 (burst done).
//  RD/WR -> same state: owner valid, same direction, at burst boundary (back-to-back, no gap).
//  RD/WR -> GAP: at burst done with no valid from the same rank and direction, TURNAROUND>0.
//   With TURNAROUND=0, go to IDLE and grant next cycle.
//  Owner valid low while counter != 0: set err_short, counter reset, -> GAP (or IDLE if TURNAROUND=0).
//  Non-owner valid in RD/WR: set err_collision; that data is ignored.
//  GAP: countdown TURNAROUND cycles, then IDLE. Any valid during GAP sets err_turnaround;
//   data is dropped, enables stay 0.
//  DQS: first RD beat dqs_t = 1, toggles each beat, dqs_c = ~dqs_t. When dqs_oe = 0: dqs_t 0, dqs_c 1.
//  err_clear: clears the flags; an error event in the same cycle wins (flag stays 1).
//  Reset mid-burst: immediate return to reset values next edge; no partial beats out.
// CONFIGURATION
//  ARB_STATS_EN defined: adds out ports rd_burst_cnt[31:0] and wr_burst_cnt[31:0].
//   Each increments on every completed full burst, wraps at 2^32, clears on reset only.
//  Not defined: ports absent, no counters.
// TESTING
//  1. Rank1 rd_valid 8 cycles, lane=0xA5.. -> dq_oe 1 cycles 1..8, dq_out=0xA5.., dqs_t 1,0,1,.., active_rank=1.
//  2. Rank0 rd burst, then rank2 rd immediately -> GAP 2 cycles, err_turnaround=1, rank2 beats dropped.
//  3. Ranks 0 and 3 rd_valid same cycle -> rank0 granted, err_collision=1; err_clear next cycle -> 0.
//  4. Rank2 wr_valid 8 beats, dq_in=0x1234.. -> only rank_wr_en[2]; other lanes 0, strb all-1.
//  5. Owner valid drops after 3 beats -> err_short=1, bus_state GAP then IDLE after 2 cycles.
//  6. Two back-to-back rank1 rd bursts -> 16 contiguous beats, no GAP; with ARB_STATS_EN rd_burst_cnt=2.

Source files
------------

// File: rtl/channel_dq_arbiter.sv
// channel_dq_arbiter: registered DQ/DQS arbiter between NUMRANK ranks and one shared channel DQ bus.
// Optional macro ARB_STATS_EN adds completed-burst counters rd_burst_cnt / wr_burst_cnt.
module channel_dq_arbiter #(
  parameter int NUMRANK       = 4,
  parameter int MEM_DATAWIDTH = 64,
  parameter int BURST_LENGTH  = 8,
  parameter int TURNAROUND    = 2,
  localparam int RW = (NUMRANK > 1) ? $clog2(NUMRANK) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUMRANK-1:0]                 rank_rd_valid,
  input  logic [NUMRANK*MEM_DATAWIDTH-1:0]   rank_rd_data,
  input  logic [NUMRANK-1:0]                 rank_wr_valid,
  input  logic [MEM_DATAWIDTH-1:0]           dq_in,
  input  logic [MEM_DATAWIDTH/8-1:0]         dm_n_in,
  input  logic                               err_clear,
  output logic [MEM_DATAWIDTH-1:0]           dq_out,
  output logic                               dq_oe,
  output logic                               dqs_t,
  output logic                               dqs_c,
  output logic                               dqs_oe,
  output logic [NUMRANK*MEM_DATAWIDTH-1:0]   rank_wr_data,
  output logic [NUMRANK*MEM_DATAWIDTH/8-1:0] rank_wr_strb,
  output logic [NUMRANK-1:0]                 rank_wr_en,
  output logic [RW-1:0]                      active_rank,
  output logic [1:0]                         bus_state,
`ifdef ARB_STATS_EN
  output logic [31:0]                        rd_burst_cnt,
  output logic [31:0]                        wr_burst_cnt,
`endif
  output logic                               err_collision,
  output logic                               err_short,
  output logic                               err_turnaround
);

  localparam int W  = MEM_DATAWIDTH;
  localparam int MW = MEM_DATAWIDTH / 8;
  localparam int CW = $clog2(BURST_LENGTH);
  localparam int GW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  // IDLE: arbitrate | RD: owner drives DQ | WR: controller writes owner | GAP: turnaround
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_GAP = 2'd3} state_t;

  state_t            state;
  logic [RW-1:0]     owner;
  logic [CW-1:0]     beat_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [NUMRANK-1:0] valid_vec, owner_mask;
  logic [RW-1:0]     grant_idx, beat_idx;
  logic any_valid, multi_valid, grant_rd, own_v, beat_go, beat_rd, burst_done;
  logic coll_evt, short_evt, ta_evt;

  assign valid_vec   = rank_rd_valid | rank_wr_valid;
  assign any_valid   = |valid_vec;
  assign multi_valid = (valid_vec & (valid_vec - NUMRANK'(1))) != '0;
  assign owner_mask  = NUMRANK'(1) << owner;
  assign bus_state   = state;
  assign active_rank = owner;

  always_comb begin
    grant_idx = '0;
    for (int i = NUMRANK - 1; i >= 0; i--)
      if (valid_vec[i]) grant_idx = RW'(i);
  end

  assign grant_rd = rank_rd_valid[grant_idx];

  always_comb begin
    own_v     = 1'b0;
    beat_go   = 1'b0;
    beat_rd   = 1'b0;
    beat_idx  = owner;
    coll_evt  = 1'b0;
    short_evt = 1'b0;
    ta_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        beat_go  = any_valid;
        beat_rd  = grant_rd;
        beat_idx = grant_idx;
        coll_evt = multi_valid;
      end
      S_RD, S_WR: begin
        own_v     = (state == S_RD) ? rank_rd_valid[owner] : rank_wr_valid[owner];
        beat_go   = own_v;
        beat_rd   = (state == S_RD);
        coll_evt  = |(valid_vec & ~owner_mask);
        short_evt = !own_v && (beat_cnt != '0);
      end
      default: ta_evt = any_valid;
    endcase
  end

  assign burst_done = own_v && (beat_cnt == CW'(BURST_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      owner          <= '0;
      beat_cnt       <= '0;
      gap_cnt        <= '0;
      dq_out         <= '0;
      dq_oe          <= 1'b0;
      dqs_oe         <= 1'b0;
      dqs_t          <= 1'b0;
      dqs_c          <= 1'b1;
      rank_wr_data   <= '0;
      rank_wr_strb   <= '1;
      rank_wr_en     <= '0;
      err_collision  <= 1'b0;
      err_short      <= 1'b0;
      err_turnaround <= 1'b0;
    end else begin
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      dqs_oe       <= 1'b0;
      dqs_t        <= 1'b0;
      dqs_c        <= 1'b1;
      rank_wr_data <= '0;
      rank_wr_strb <= '1;
      rank_wr_en   <= '0;

      if (beat_go) begin
        if (beat_rd) begin
          dq_out <= rank_rd_data[beat_idx*W +: W];
          dq_oe  <= 1'b1;
          dqs_oe <= 1'b1;
          // A fresh grant restarts the strobe high; continuing beats toggle it.
          dqs_t  <= (state == S_IDLE) ? 1'b1 : ~dqs_t;
          dqs_c  <= (state == S_IDLE) ? 1'b0 : dqs_t;
        end else begin
          rank_wr_data[beat_idx*W +: W]   <= dq_in;
          rank_wr_strb[beat_idx*MW +: MW] <= dm_n_in;
          rank_wr_en[beat_idx]            <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (any_valid) begin
            owner    <= grant_idx;
            state    <= grant_rd ? S_RD : S_WR;
            beat_cnt <= CW'(1);
          end
        end
        S_RD, S_WR: begin
          if (own_v) begin
            beat_cnt <= burst_done ? '0 : beat_cnt + CW'(1);
          end else begin
            beat_cnt <= '0;
            if (TURNAROUND > 0) begin
              state   <= S_GAP;
              gap_cnt <= GW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - GW'(1);
        end
      endcase

      err_collision  <= (err_collision  & ~err_clear) | coll_evt;
      err_short      <= (err_short      & ~err_clear) | short_evt;
      err_turnaround <= (err_turnaround & ~err_clear) | ta_evt;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_burst_cnt <= '0;
      wr_burst_cnt <= '0;
    end else if (burst_done) begin
      if (state == S_RD) rd_burst_cnt <= rd_burst_cnt + 32'd1;
      else wr_burst_cnt <= wr_burst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_dq_arbiter.sv
// Directed bench for channel_dq_arbiter (4 ranks, 64-bit DQ, BL8, turnaround 2).
module tb_channel_dq_arbiter;
  localparam int NR = 4;
  localparam int W  = 64;
  localparam int BL = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     rank_rd_valid, rank_wr_valid, rank_wr_en;
  logic [NR*W-1:0]   rank_rd_data, rank_wr_data;
  logic [W-1:0]      dq_in, dq_out;
  logic [W/8-1:0]    dm_n_in;
  logic              err_clear, dq_oe, dqs_t, dqs_c, dqs_oe;
  logic [NR*W/8-1:0] rank_wr_strb;
  logic [1:0]        active_rank, bus_state;
  logic              err_collision, err_short, err_turnaround;
`ifdef ARB_STATS_EN
  logic [31:0]       rd_burst_cnt, wr_burst_cnt;
  int                exp_rd = 0, exp_wr = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  channel_dq_arbiter #(.NUMRANK(NR), .MEM_DATAWIDTH(W), .BURST_LENGTH(BL), .TURNAROUND(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rank_rd_valid(rank_rd_valid), .rank_rd_data(rank_rd_data),
    .rank_wr_valid(rank_wr_valid), .dq_in(dq_in), .dm_n_in(dm_n_in), .err_clear(err_clear),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dqs_oe(dqs_oe),
    .rank_wr_data(rank_wr_data), .rank_wr_strb(rank_wr_strb), .rank_wr_en(rank_wr_en),
    .active_rank(active_rank), .bus_state(bus_state),
`ifdef ARB_STATS_EN
    .rd_burst_cnt(rd_burst_cnt), .wr_burst_cnt(wr_burst_cnt),
`endif
    .err_collision(err_collision), .err_short(err_short), .err_turnaround(err_turnaround)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rank_rd_valid = '0;
    rank_wr_valid = '0;
    rank_rd_data  = '0;
    dq_in         = '0;
    dm_n_in       = '1;
    err_clear     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d exp 0", bus_state); end
    n_cmp++; if ({dq_oe, dqs_oe, dqs_t, dqs_c} !== 4'b0001) begin n_bad++; $display("FAIL reset_dq: got oe/dqsoe/t/c %b exp 0001", {dq_oe, dqs_oe, dqs_t, dqs_c}); end
    n_cmp++; if (rank_wr_strb !== '1 || rank_wr_en !== '0 || rank_wr_data !== '0 || dq_out !== '0) begin n_bad++; $display("FAIL reset_paths: strb %h en %b", rank_wr_strb, rank_wr_en); end
    n_cmp++; if ({active_rank, err_collision, err_short, err_turnaround} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b exp 00000", {active_rank, err_collision, err_short, err_turnaround}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rd_burst();
    logic [W-1:0] lane;
    for (int i = 0; i < BL; i++) begin
      lane = {56'hA5A5_A5A5_A5A5_A5, 8'(i)};
      rank_rd_valid = 4'b0010;
      rank_rd_data  = '0;
      rank_rd_data[1*W +: W] = lane;
      tick();
      n_cmp++; if (dq_oe !== 1'b1 || dqs_oe !== 1'b1) begin n_bad++; $display("FAIL rd_oe beat %0d: got %b%b exp 11", i, dq_oe, dqs_oe); end
      n_cmp++; if (dq_out !== lane) begin n_bad++; $display("FAIL rd_data beat %0d: got %h exp %h", i, dq_out, lane); end
      n_cmp++; if (dqs_t !== (i % 2 == 0) || dqs_c !== (i % 2 != 0)) begin n_bad++; $display("FAIL rd_dqs beat %0d: got t%b c%b", i, dqs_t, dqs_c); end
      n_cmp++; if (active_rank !== 2'd1 || bus_state !== 2'd1) begin n_bad++; $display("FAIL rd_owner beat %0d: got rank %0d state %0d exp 1 1", i, active_rank, bus_state); end
    end
    clear_inputs();
    tick();
    n_cmp++; if (bus_state !== 2'd3 || dq_oe !== 1'b0 || dqs_t !== 1'b0 || dqs_c !== 1'b1) begin n_bad++; $display("FAIL rd_end: state %0d oe %b t%b c%b exp 3 0 0 1", bus_state, dq_oe, dqs_t, dqs_c); end
    tick();
    n_cmp++; if (bus_state !== 2'd3) begin n_bad++; $display("FAIL rd_gap2: got %0d exp 3", bus_state); end
    tick();
    n_cmp++; if (bus_state !== 2'd0) begin n_bad++; $display("FAIL rd_idle: got %0d exp 0", bus_state); end
`ifdef ARB_STATS_EN
    exp_rd++;
`endif
  endtask

  task automatic test_collision();
    rank_rd_valid = 4'b1001;
    rank_rd_data  = '0;
    rank_rd_data[0*W +: W] = 64'h0000_0000_0000_C0DE;
    rank_rd_data[3*W +: W] = 64'h3333_3333_3333_3333;
    tick();
    n_cmp++; if (active_rank !== 2'd0 || bus_state !== 2'd1) begin n_bad++; $display("FAIL coll_grant: rank %0d state %0d exp 0 1", active_rank, bus_state); end
    n_cmp++; if (dq_out !== 64'h0000_0000_0000_C0DE) begin n_bad++; $display("FAIL coll_data: got %h exp c0de", dq_out); end
    n_cmp++; if (err_collision !== 1'b1) begin n_bad++; $display("FAIL coll_flag: got %b exp 1", err_collision); end
    rank_rd_valid = 4'b0001;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_cmp++; if (err_collision !== 1'b0) begin n_bad++; $display("FAIL coll_clear: got %b exp 0", err_collision); end
    for (int i = 2; i < BL; i++) tick();
    n_cmp++; if (dq_oe !== 1'b1 || bus_state !== 2'd1 || err_short !== 1'b0) begin n_bad++; $display("FAIL coll_burst: oe %b state %0d short %b", dq_oe, bus_state, err_short); end
    clear_inputs();
    tick(); tick(); tick();
    n_cmp++; if (bus_state !== 2'd0) begin n_bad++; $display("FAIL coll_idle: got %0d exp 0", bus_state); end
`ifdef ARB_STATS_EN
    exp_rd++;
`endif
  endtask

  task automatic test_turnaround();
    for (int i = 0; i < BL; i++) begin
      rank_rd_valid = 4'b0001;
      rank_rd_data  = '0;
      rank_rd_data[0*W +: W] = 64'h0F0F_0000_0000_0000 | 64'(i);
      tick();
    end
    n_cmp++; if (dq_out !== 64'h0F0F_0000_0000_0007 || bus_state !== 2'd1) begin n_bad++; $display("FAIL ta_last: data %h state %0d", dq_out, bus_state); end
    rank_rd_valid = 4'b0100;
    rank_rd_data  = '0;
    rank_rd_data[2*W +: W] = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    n_cmp++; if (bus_state !== 2'd3 || dq_oe !== 1'b0) begin n_bad++; $display("FAIL ta_enter: state %0d oe %b exp 3 0", bus_state, dq_oe); end
    n_cmp++; if (err_turnaround !== 1'b0) begin n_bad++; $display("FAIL ta_early: got %b exp 0", err_turnaround); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_cmp++; if (bus_state !== 2'd3 || dq_oe !== 1'b0) begin n_bad++; $display("FAIL ta_gap: state %0d oe %b exp 3 0", bus_state, dq_oe); end
    n_cmp++; if (err_turnaround !== 1'b1 || err_collision !== 1'b0) begin n_bad++; $display("FAIL ta_flags: ta %b coll %b exp 1 0", err_turnaround, err_collision); end
    tick();
    n_cmp++; if (bus_state !== 2'd0 || dq_oe !== 1'b0 || err_turnaround !== 1'b1) begin n_bad++; $display("FAIL ta_idle: state %0d oe %b ta %b", bus_state, dq_oe, err_turnaround); end
    clear_inputs();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_cmp++; if (err_turnaround !== 1'b0 || bus_state !== 2'd0) begin n_bad++; $display("FAIL ta_clear: ta %b state %0d", err_turnaround, bus_state); end
`ifdef ARB_STATS_EN
    exp_rd++;
`endif
  endtask

  task automatic test_write();
    logic [NR*W-1:0]   exp_data;
    logic [NR*W/8-1:0] exp_strb;
    for (int i = 0; i < BL; i++) begin
      rank_wr_valid = 4'b0100;
      dq_in   = 64'h1234_5678_9ABC_DE00 | 64'(i);
      dm_n_in = 8'hF0 ^ 8'(i);
      exp_data = '0;
      exp_data[2*W +: W] = dq_in;
      exp_strb = '1;
      exp_strb[2*8 +: 8] = dm_n_in;
      tick();
      n_cmp++; if (rank_wr_en !== 4'b0100) begin n_bad++; $display("FAIL wr_en beat %0d: got %b exp 0100", i, rank_wr_en); end
      n_cmp++; if (rank_wr_data !== exp_data) begin n_bad++; $display("FAIL wr_data beat %0d: got %h exp %h", i, rank_wr_data, exp_data); end
      n_cmp++; if (rank_wr_strb !== exp_strb) begin n_bad++; $display("FAIL wr_strb beat %0d: got %h exp %h", i, rank_wr_strb, exp_strb); end
      n_cmp++; if (bus_state !== 2'd2 || dq_oe !== 1'b0 || active_rank !== 2'd2) begin n_bad++; $display("FAIL wr_state beat %0d: state %0d oe %b rank %0d", i, bus_state, dq_oe, active_rank); end
    end
    clear_inputs();
    tick();
    n_cmp++; if (rank_wr_en !== '0 || rank_wr_strb !== '1 || bus_state !== 2'd3) begin n_bad++; $display("FAIL wr_end: en %b state %0d", rank_wr_en, bus_state); end
    tick(); tick();
`ifdef ARB_STATS_EN
    exp_wr++;
`endif
  endtask

  task automatic test_short();
    for (int i = 0; i < 3; i++) begin
      rank_rd_valid = 4'b0010;
      tick();
    end
    n_cmp++; if (err_short !== 1'b0 || bus_state !== 2'd1) begin n_bad++; $display("FAIL short_pre: short %b state %0d", err_short, bus_state); end
    clear_inputs();
    tick();
    n_cmp++; if (err_short !== 1'b1 || bus_state !== 2'd3 || dq_oe !== 1'b0) begin n_bad++; $display("FAIL short_flag: short %b state %0d oe %b exp 1 3 0", err_short, bus_state, dq_oe); end
    tick();
    n_cmp++; if (bus_state !== 2'd3) begin n_bad++; $display("FAIL short_gap: got %0d exp 3", bus_state); end
    tick();
    n_cmp++; if (bus_state !== 2'd0 || err_short !== 1'b1) begin n_bad++; $display("FAIL short_idle: state %0d short %b", bus_state, err_short); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_cmp++; if (err_short !== 1'b0) begin n_bad++; $display("FAIL short_clear: got %b exp 0", err_short); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] lane;
    for (int i = 0; i < 2 * BL; i++) begin
      lane = 64'hB2B0_0000_0000_0000 | 64'(i);
      rank_rd_valid = 4'b0010;
      rank_rd_data  = '0;
      rank_rd_data[1*W +: W] = lane;
      tick();
      n_cmp++; if (bus_state !== 2'd1 || dq_oe !== 1'b1 || dq_out !== lane) begin n_bad++; $display("FAIL b2b beat %0d: state %0d oe %b data %h exp %h", i, bus_state, dq_oe, dq_out, lane); end
      n_cmp++; if (dqs_t !== (i % 2 == 0)) begin n_bad++; $display("FAIL b2b_dqs beat %0d: got %b", i, dqs_t); end
    end
    clear_inputs();
    tick();
    n_cmp++; if (bus_state !== 2'd3 || err_short !== 1'b0) begin n_bad++; $display("FAIL b2b_end: state %0d short %b", bus_state, err_short); end
    tick(); tick();
`ifdef ARB_STATS_EN
    exp_rd += 2;
    n_cmp++; if (rd_burst_cnt !== 32'(exp_rd)) begin n_bad++; $display("FAIL stats_rd: got %0d exp %0d", rd_burst_cnt, exp_rd); end
    n_cmp++; if (wr_burst_cnt !== 32'(exp_wr)) begin n_bad++; $display("FAIL stats_wr: got %0d exp %0d", wr_burst_cnt, exp_wr); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      rank_rd_valid = 4'b1000;
      rank_rd_data  = '0;
      rank_rd_data[3*W +: W] = 64'h7777_0000_0000_0000 | 64'(i);
      tick();
    end
    n_cmp++; if (active_rank !== 2'd3 || dq_oe !== 1'b1) begin n_bad++; $display("FAIL rst_pre: rank %0d oe %b", active_rank, dq_oe); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus_state !== 2'd0 || dq_oe !== 1'b0 || dqs_oe !== 1'b0 || dq_out !== '0) begin n_bad++; $display("FAIL rst_mid: state %0d oe %b dqsoe %b data %h", bus_state, dq_oe, dqs_oe, dq_out); end
    n_cmp++; if (active_rank !== 2'd0 || dqs_t !== 1'b0 || dqs_c !== 1'b1) begin n_bad++; $display("FAIL rst_mid_rank: rank %0d t%b c%b", active_rank, dqs_t, dqs_c); end
`ifdef ARB_STATS_EN
    n_cmp++; if (rd_burst_cnt !== 32'd0 || wr_burst_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_stats: rd %0d wr %0d", rd_burst_cnt, wr_burst_cnt); end
`endif
    rst_n = 1'b1;
    clear_inputs();
    tick();
    n_cmp++; if (bus_state !== 2'd0 || dq_oe !== 1'b0) begin n_bad++; $display("FAIL rst_after: state %0d oe %b", bus_state, dq_oe); end
  endtask

  initial begin
    test_reset();
    test_rd_burst();
    test_collision();
    test_turnaround();
    test_write();
    test_short();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
